// File: rtl/event_pending_latch_pkg.sv
// Shared definitions for the event pending latch: slot state encoding and
// the event detect helper used by the top level.
package event_pending_latch_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HOLDOFF = 2'd2
  } slot_state_e;

  // Rising-edge mode compares against last cycle's input; level mode treats
  // every high cycle as an event.
  function automatic logic detect_event(input logic edge_mode,
                                        input logic cur,
                                        input logic prev);
    return edge_mode ? (cur & ~prev) : cur;
  endfunction

endpackage

// File: rtl/event_pending_latch_if.sv
// Bundle of event inputs, configuration, per-source request handshake and
// overflow reporting between the latch (slave) and its environment (master).
interface event_pending_latch_if #(
  parameter int COUNT        = 16,
  parameter int HOLDOFF_BITS = 8
);
  import event_pending_latch_pkg::*;

  logic [COUNT-1:0]              s_event_in;
  logic [COUNT-1:0]              cfg_mask;
  logic [HOLDOFF_BITS-1:0]       cfg_holdoff;
  // Handshake: source i transfers in a cycle where m_event_valid[i] and
  // m_event_ready[i] are both high; valid never waits on ready, and ready
  // without valid has no effect. Ready is at most one-hot.
  logic [COUNT-1:0]              m_event_valid;
  logic [COUNT-1:0]              m_event_ready;
  logic [COUNT-1:0]              ovf_flags;
  logic [COUNT-1:0]              ovf_clear;
  logic [COUNT-1:0][STATE_W-1:0] dbg_slot_state;

  modport slave (
    input  s_event_in, cfg_mask, cfg_holdoff, m_event_ready, ovf_clear,
    output m_event_valid, ovf_flags, dbg_slot_state
  );

  modport master (
    output s_event_in, cfg_mask, cfg_holdoff, m_event_ready, ovf_clear,
    input  m_event_valid, ovf_flags, dbg_slot_state
  );

endinterface

// File: rtl/event_pending_slot.sv
// One source's request slot: IDLE/PENDING/HOLDOFF state, re-arm counter,
// single-deep deferred event and sticky overflow flag.
module event_pending_slot
  import event_pending_latch_pkg::*;
#(
  parameter int HOLDOFF_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ev,
  input  logic                    hs,
  input  logic [HOLDOFF_BITS-1:0] holdoff,
  input  logic                    ovf_clear,
  output logic                    pending,
  output logic                    ovf,
  output logic [STATE_W-1:0]      state_o
);

  localparam logic [HOLDOFF_BITS-1:0] CNT_ONE = HOLDOFF_BITS'(1);

  slot_state_e             state_q, state_d;
  logic [HOLDOFF_BITS-1:0] cnt_q, cnt_d;
  logic                    deferred_q, deferred_d;
  logic                    ovf_q, ovf_d;
  logic                    ovf_set;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    deferred_d = deferred_q;
    ovf_set    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ev) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (hs) begin
          if (holdoff == '0) begin
            state_d = ev ? ST_PENDING : ST_IDLE;
          end else begin
            state_d    = ST_HOLDOFF;
            cnt_d      = holdoff;
            deferred_d = ev;
          end
        end else if (ev) begin
          ovf_set = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (ev && deferred_q) ovf_set = 1'b1;
        // The interval was latched on entry, so cfg changes cannot stretch it.
        if (cnt_q == CNT_ONE) begin
          state_d    = (deferred_q || ev) ? ST_PENDING : ST_IDLE;
          cnt_d      = '0;
          deferred_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (ev) deferred_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        deferred_d = 1'b0;
      end
    endcase
    // A new overflow beats a clear arriving in the same cycle.
    ovf_d = ovf_set | (ovf_q & ~ovf_clear);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      deferred_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      deferred_q <= deferred_d;
      ovf_q      <= ovf_d;
    end
  end

  assign pending = (state_q == ST_PENDING);
  assign ovf     = ovf_q;
  assign state_o = state_q;

endmodule

// File: rtl/event_pending_latch.sv
// Per-source event capture in front of the event serializer: edge/level
// detect, one pending slot per source, and mask gating of the requests.
module event_pending_latch
  import event_pending_latch_pkg::*;
#(
  parameter int COUNT        = 16,
  parameter int HOLDOFF_BITS = 8,
  parameter int EDGE         = 1
) (
  input logic                  clk,
  input logic                  rst,
  event_pending_latch_if.slave bus
);

  logic [COUNT-1:0]              in_d_q, in_d_d;
  logic [COUNT-1:0]              ev;
  logic [COUNT-1:0]              hs;
  logic [COUNT-1:0]              pending;
  logic [COUNT-1:0]              valid;
  logic [COUNT-1:0]              ovf;
  logic [COUNT-1:0][STATE_W-1:0] slot_state;

  always_comb in_d_d = bus.s_event_in;

  always_ff @(posedge clk) begin
    if (rst) in_d_q <= '0;
    else     in_d_q <= in_d_d;
  end

  // Masking hides a pending request without dropping it.
  assign valid = pending & ~bus.cfg_mask;

  for (genvar i = 0; i < COUNT; i++) begin : g_slot
    // Masked sources see no events at all, so they can neither arm nor overflow.
    assign ev[i] = detect_event(EDGE != 0, bus.s_event_in[i], in_d_q[i])
                   & ~bus.cfg_mask[i];
    assign hs[i] = valid[i] & bus.m_event_ready[i];

    event_pending_slot #(
      .HOLDOFF_BITS(HOLDOFF_BITS)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .ev        (ev[i]),
      .hs        (hs[i]),
      .holdoff   (bus.cfg_holdoff),
      .ovf_clear (bus.ovf_clear[i]),
      .pending   (pending[i]),
      .ovf       (ovf[i]),
      .state_o   (slot_state[i])
    );
  end

  assign bus.m_event_valid  = valid;
  assign bus.ovf_flags      = ovf;
  assign bus.dbg_slot_state = slot_state;

endmodule

// File: tb/tb_event_pending_latch.sv
// Directed bench for event_pending_latch: an EDGE=1 and an EDGE=0 instance
// share stimulus and are checked every cycle against a timestamp model.
module tb_event_pending_latch;

  localparam int COUNT = 16;
  localparam int HB    = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [COUNT-1:0] s_in, mask, ready, clr;
  logic [HB-1:0]    hold;

  event_pending_latch_if #(.COUNT(COUNT), .HOLDOFF_BITS(HB)) ifa ();
  event_pending_latch_if #(.COUNT(COUNT), .HOLDOFF_BITS(HB)) ifb ();

  assign ifa.s_event_in    = s_in;
  assign ifa.cfg_mask      = mask;
  assign ifa.cfg_holdoff   = hold;
  assign ifa.m_event_ready = ready;
  assign ifa.ovf_clear     = clr;
  assign ifb.s_event_in    = s_in;
  assign ifb.cfg_mask      = mask;
  assign ifb.cfg_holdoff   = hold;
  assign ifb.m_event_ready = ready;
  assign ifb.ovf_clear     = clr;

  event_pending_latch #(.COUNT(COUNT), .HOLDOFF_BITS(HB), .EDGE(1)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  event_pending_latch #(.COUNT(COUNT), .HOLDOFF_BITS(HB), .EDGE(0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [COUNT-1:0] act,
                       input logic [COUNT-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per source: outstanding request, deferred event, cycle at which the
  // re-arm interval ends (-1 when not in one), overflow.
  logic [COUNT-1:0] m_req [2];
  logic [COUNT-1:0] m_def [2];
  logic [COUNT-1:0] m_ovf [2];
  logic [COUNT-1:0] m_prev[2];
  int               m_exit[2][COUNT];
  int               cyc     = 0;
  bit               started = 0;

  always @(posedge clk) begin : model
    logic ev, hs, setv;
    started = 1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < COUNT; i++) begin
        if (rst) begin
          m_req[d][i] = 1'b0;
          m_def[d][i] = 1'b0;
          m_ovf[d][i] = 1'b0;
          m_exit[d][i] = -1;
        end else begin
          ev   = (d == 0 ? (s_in[i] & ~m_prev[d][i]) : s_in[i]) & ~mask[i];
          hs   = m_req[d][i] & ~mask[i] & ready[i];
          setv = 1'b0;
          if (m_exit[d][i] >= cyc) begin
            if (ev) begin
              if (m_def[d][i]) setv = 1'b1;
              else             m_def[d][i] = 1'b1;
            end
            if (cyc == m_exit[d][i]) begin
              m_req[d][i]  = m_def[d][i];
              m_def[d][i]  = 1'b0;
              m_exit[d][i] = -1;
            end
          end else if (m_req[d][i]) begin
            if (hs) begin
              if (hold == '0) begin
                m_req[d][i] = ev;
              end else begin
                m_req[d][i]  = 1'b0;
                m_def[d][i]  = ev;
                m_exit[d][i] = cyc + int'(hold);
              end
            end else if (ev) begin
              setv = 1'b1;
            end
          end else if (ev) begin
            m_req[d][i] = 1'b1;
          end
          m_ovf[d][i] = setv | (m_ovf[d][i] & ~clr[i]);
        end
      end
      m_prev[d] = rst ? '0 : s_in;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      check("valid_a", ifa.m_event_valid, m_req[0] & ~mask);
      check("ovf_a",   ifa.ovf_flags,     m_ovf[0]);
      check("valid_b", ifb.m_event_valid, m_req[1] & ~mask);
      check("ovf_b",   ifb.ovf_flags,     m_ovf[1]);
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; s_in = '0; mask = '0; ready = '0; clr = '0; hold = '0;
    ticks(3);
    check("rst_valid", ifa.m_event_valid, 16'h0000);
    check("rst_ovf",   ifa.ovf_flags,     16'h0000);
    rst = 1'b0;
    tick();

    // single pulse on source 3, held until ready
    s_in = 16'h0008; tick();
    check("pulse_t1_a", ifa.m_event_valid, 16'h0008);
    check("pulse_t1_b", ifb.m_event_valid, 16'h0008);
    s_in = '0; ticks(2);
    check("pulse_hold", ifa.m_event_valid, 16'h0008);
    ready = 16'h0008; tick(); ready = '0;
    check("pulse_done", ifa.m_event_valid, 16'h0000);
    check("pulse_ovf",  ifa.ovf_flags,     16'h0000);

    // level held high 10 cycles on source 0
    s_in = 16'h0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) check("level_first_ovf_b", ifb.ovf_flags, 16'h0000);
      if (i == 1) check("level_second_ovf_b", ifb.ovf_flags, 16'h0001);
    end
    s_in = '0;
    check("level_valid_a", ifa.m_event_valid, 16'h0001);
    check("level_ovf_a",   ifa.ovf_flags,     16'h0000);
    check("level_ovf_b",   ifb.ovf_flags,     16'h0001);
    ready = 16'h0001; tick(); ready = '0;
    check("level_drain_a", ifa.m_event_valid, 16'h0000);
    check("level_drain_b", ifb.m_event_valid, 16'h0000);
    clr = 16'h0001; tick(); clr = '0;
    check("level_clear_b", ifb.ovf_flags, 16'h0000);

    // holdoff of 4 on source 2 with one deferred event
    hold = 8'd4;
    s_in = 16'h0004; tick(); s_in = '0; tick();
    ready = 16'h0004; tick(); ready = '0;
    check("hold_t1", ifa.m_event_valid, 16'h0000);
    tick(); s_in = 16'h0004;
    check("hold_t2", ifa.m_event_valid, 16'h0000);
    tick(); s_in = '0;
    check("hold_t3", ifa.m_event_valid, 16'h0000);
    tick();
    check("hold_t4", ifa.m_event_valid, 16'h0000);
    tick();
    check("hold_t5_a", ifa.m_event_valid, 16'h0004);
    check("hold_t5_b", ifb.m_event_valid, 16'h0004);
    check("hold_noovf", ifa.ovf_flags, 16'h0000);

    // second event during the same holdoff overflows
    ready = 16'h0004; tick(); ready = '0;
    s_in = 16'h0004; tick(); s_in = '0; tick();
    s_in = 16'h0004; tick(); s_in = '0;
    check("hold_ovf_a", ifa.ovf_flags, 16'h0004);
    check("hold_ovf_b", ifb.ovf_flags, 16'h0004);
    tick();
    check("hold_redeliver", ifa.m_event_valid, 16'h0004);

    // interval latched at entry; later cfg change must not matter
    ready = 16'h0004; tick(); ready = '0; hold = 8'd0;
    tick();
    check("latched_t2", ifa.m_event_valid, 16'h0000);
    ticks(3);
    check("latched_t5", ifa.m_event_valid, 16'h0000);
    clr = 16'h0004; tick(); clr = '0;
    check("hold_clear", ifa.ovf_flags, 16'h0000);

    // zero holdoff: event coincident with handshake keeps request
    s_in = 16'h0010; tick(); s_in = '0; tick();
    ready = 16'h0010; s_in = 16'h0010; tick(); ready = '0; s_in = '0;
    check("coinc_t1", ifa.m_event_valid, 16'h0010);
    tick();
    check("coinc_t2", ifa.m_event_valid, 16'h0010);
    check("coinc_ovf", ifa.ovf_flags, 16'h0000);
    ready = 16'h0010; tick(); ready = '0;
    check("coinc_drain", ifa.m_event_valid, 16'h0000);

    // masking a pending source
    s_in = 16'h0020; tick(); s_in = '0; tick();
    check("mask_pend", ifa.m_event_valid, 16'h0020);
    mask = 16'h0020; #1;
    check("mask_hidden", ifa.m_event_valid, 16'h0000);
    s_in = 16'h0020; tick(); s_in = '0; tick();
    s_in = 16'h0020; tick(); s_in = '0; tick();
    check("mask_noovf_a", ifa.ovf_flags, 16'h0000);
    check("mask_noovf_b", ifb.ovf_flags, 16'h0000);
    mask = '0; #1;
    check("mask_restore", ifa.m_event_valid, 16'h0020);
    ready = 16'h0020; tick(); ready = '0;
    check("mask_drain", ifa.m_event_valid, 16'h0000);

    // overflow set wins over a same-cycle clear on source 1
    s_in = 16'h0002; tick(); s_in = '0; tick();
    s_in = 16'h0002; tick(); s_in = '0; tick();
    check("ovf1_set", ifa.ovf_flags, 16'h0002);
    s_in = 16'h0002; clr = 16'h0002; tick(); s_in = '0; clr = '0;
    check("ovf1_setwins_a", ifa.ovf_flags, 16'h0002);
    check("ovf1_setwins_b", ifb.ovf_flags, 16'h0002);
    clr = 16'h0002; tick(); clr = '0;
    check("ovf1_cleared", ifa.ovf_flags, 16'h0000);
    ready = 16'h0002; tick(); ready = '0;

    // reset mid-holdoff with deferred set and another source overflowed
    hold = 8'd8;
    s_in = 16'h0040; tick(); s_in = '0; tick();
    s_in = 16'h0040; tick(); s_in = '0; tick();
    s_in = 16'h0001; tick(); s_in = '0; tick();
    ready = 16'h0001; tick(); ready = '0;
    s_in = 16'h0001; tick(); s_in = '0;
    check("prerst_ovf", ifa.ovf_flags, 16'h0040);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_valid_a", ifa.m_event_valid, 16'h0000);
    check("rst_mid_ovf_a",   ifa.ovf_flags,     16'h0000);
    check("rst_mid_valid_b", ifb.m_event_valid, 16'h0000);
    check("rst_mid_ovf_b",   ifb.ovf_flags,     16'h0000);
    ticks(12);
    check("rst_after_a", ifa.m_event_valid, 16'h0000);
    check("rst_after_b", ifb.m_event_valid, 16'h0000);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
